// File: rtl/note_arbiter.sv
// Fixed-priority arbiter sharing one tone generator among three note sources,
// with a forced GAP_CYCLES silence between owners. Define NOTE_ARB_PREEMPT_EN for preemption.
module note_arbiter #(
    parameter int unsigned GAP_CYCLES = 1000
) (
    input  logic        clk,
    input  logic        rst,
    input  logic [2:0]  req_on,
    input  logic [11:0] req_key,
    output logic        tone_on,
    output logic [3:0]  tone_key,
    output logic [2:0]  grant,
    output logic        busy,
    output logic [7:0]  preempt_cnt
);

    // state | meaning
    // IDLE  | no owner, arbitrate on every edge
    // PLAY  | grant holds the owner, tone follows its key
    // GAP   | forced silence, requests ignored until count expires
    typedef enum logic [1:0] {IDLE, PLAY, GAP} state_t;

    localparam logic [15:0] GAP_LAST = 16'(GAP_CYCLES - 1);

    state_t      state, state_nx;
    logic [15:0] gap_cnt, gap_cnt_nx;
    logic        tone_on_nx, busy_nx;
    logic [3:0]  tone_key_nx;
    logic [2:0]  grant_nx;
    logic [2:0]  pick;
    logic [3:0]  pick_key;
    logic        owner_on;
    logic [3:0]  owner_key;

`ifdef NOTE_ARB_PREEMPT_EN
    logic [7:0] pcnt, pcnt_nx;
    logic       higher;
    // grant is one-hot during PLAY, so grant-1 masks every higher-priority bit
    assign higher = |(req_on & (grant - 3'd1));
    assign preempt_cnt = pcnt;
`else
    assign preempt_cnt = 8'd0;
`endif

    assign owner_on = |(req_on & grant);

    always_comb begin
        pick     = 3'b000;
        pick_key = req_key[3:0];
        if (req_on[0]) begin
            pick     = 3'b001;
            pick_key = req_key[3:0];
        end else if (req_on[1]) begin
            pick     = 3'b010;
            pick_key = req_key[7:4];
        end else if (req_on[2]) begin
            pick     = 3'b100;
            pick_key = req_key[11:8];
        end
    end

    always_comb begin
        owner_key = req_key[3:0];
        case (grant)
            3'b010:  owner_key = req_key[7:4];
            3'b100:  owner_key = req_key[11:8];
            default: owner_key = req_key[3:0];
        endcase
    end

    always_comb begin
        state_nx    = state;
        gap_cnt_nx  = gap_cnt;
        tone_on_nx  = tone_on;
        tone_key_nx = tone_key;
        grant_nx    = grant;
        busy_nx     = busy;
`ifdef NOTE_ARB_PREEMPT_EN
        pcnt_nx     = pcnt;
`endif
        case (state)
            IDLE: begin
                if (|req_on) begin
                    state_nx    = PLAY;
                    grant_nx    = pick;
                    tone_on_nx  = 1'b1;
                    tone_key_nx = pick_key;
                    busy_nx     = 1'b1;
                end else begin
                    tone_on_nx = 1'b0;
                    grant_nx   = 3'b000;
                    busy_nx    = 1'b0;
                end
            end
            PLAY: begin
                if (!owner_on) begin
                    state_nx   = GAP;
                    gap_cnt_nx = 16'd0;
                    tone_on_nx = 1'b0;
                    grant_nx   = 3'b000;
`ifdef NOTE_ARB_PREEMPT_EN
                end else if (higher) begin
                    state_nx   = GAP;
                    gap_cnt_nx = 16'd0;
                    tone_on_nx = 1'b0;
                    grant_nx   = 3'b000;
                    if (pcnt != 8'hFF)
                        pcnt_nx = pcnt + 8'd1;
`endif
                end else begin
                    tone_key_nx = owner_key;
                end
            end
            GAP: begin
                if (gap_cnt == GAP_LAST) begin
                    state_nx   = IDLE;
                    gap_cnt_nx = 16'd0;
                    busy_nx    = 1'b0;
                end else begin
                    gap_cnt_nx = gap_cnt + 16'd1;
                end
            end
            default: begin
                state_nx   = IDLE;
                gap_cnt_nx = 16'd0;
                tone_on_nx = 1'b0;
                grant_nx   = 3'b000;
                busy_nx    = 1'b0;
            end
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state    <= IDLE;
            gap_cnt  <= 16'd0;
            tone_on  <= 1'b0;
            tone_key <= 4'd0;
            grant    <= 3'b000;
            busy     <= 1'b0;
`ifdef NOTE_ARB_PREEMPT_EN
            pcnt     <= 8'd0;
`endif
        end else begin
            state    <= state_nx;
            gap_cnt  <= gap_cnt_nx;
            tone_on  <= tone_on_nx;
            tone_key <= tone_key_nx;
            grant    <= grant_nx;
            busy     <= busy_nx;
`ifdef NOTE_ARB_PREEMPT_EN
            pcnt     <= pcnt_nx;
`endif
        end
    end

endmodule

// File: tb/tb_note_arbiter.sv
// Directed bench for note_arbiter with GAP_CYCLES = 4; expectations follow the
// NOTE_ARB_PREEMPT_EN setting of the build.
module tb_note_arbiter;

    logic        clk;
    logic        rst;
    logic [2:0]  req_on;
    logic [11:0] req_key;
    logic        tone_on;
    logic [3:0]  tone_key;
    logic [2:0]  grant;
    logic        busy;
    logic [7:0]  preempt_cnt;

    int n_chk  = 0;
    int n_pass = 0;
    int exp_pc = 0;

    note_arbiter #(.GAP_CYCLES(4)) dut (
        .clk         (clk),
        .rst         (rst),
        .req_on      (req_on),
        .req_key     (req_key),
        .tone_on     (tone_on),
        .tone_key    (tone_key),
        .grant       (grant),
        .busy        (busy),
        .preempt_cnt (preempt_cnt)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_chk++;
        if (got === exp) n_pass++;
        else $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
        chk("onehot_grant", 32'($onehot0(grant)), 32'd1);
        chk("tone_implies_grant", 32'(!tone_on || (grant != 3'b000)), 32'd1);
    endtask

    task automatic wait_idle();
        for (int i = 0; i < 20 && busy; i++) tick();
        chk("idle_reached", 32'(busy), 32'd0);
    endtask

    task automatic check_all(input string tag, input logic t_on, input logic [3:0] t_key,
                             input logic [2:0] g, input logic b);
        chk({tag, "_tone_on"}, 32'(tone_on), 32'(t_on));
        chk({tag, "_tone_key"}, 32'(tone_key), 32'(t_key));
        chk({tag, "_grant"}, 32'(grant), 32'(g));
        chk({tag, "_busy"}, 32'(busy), 32'(b));
        chk({tag, "_pcnt"}, 32'(preempt_cnt), 32'(exp_pc));
    endtask

    initial begin
`ifdef NOTE_ARB_PREEMPT_EN
        bit pre = 1'b1;
`else
        bit pre = 1'b0;
`endif
        rst = 1'b1; req_on = 3'b000; req_key = 12'h000;
        #3;
        check_all("reset", 1'b0, 4'd0, 3'b000, 1'b0);
        #5 rst = 1'b0;

        // single request, granted on the first edge after reset
        req_on = 3'b001; req_key = 12'h005;
        tick();
        check_all("single", 1'b1, 4'd5, 3'b001, 1'b1);
        repeat (8) tick();
        req_on = 3'b000;
        tick();
        check_all("release", 1'b0, 4'd5, 3'b000, 1'b1);
        req_on = 3'b100;
        repeat (3) tick();
        chk("gap_ignores_req_grant", 32'(grant), 32'd0);
        chk("gap_busy", 32'(busy), 32'd1);
        req_on = 3'b000;
        tick();
        chk("gap_len_idle", 32'(busy), 32'd0);
        tick();
        check_all("idle_hold", 1'b0, 4'd5, 3'b000, 1'b0);

        // simultaneous request and legato with a lower-priority requester pending
        req_on = 3'b110; req_key = 12'h930;
        tick();
        check_all("simul", 1'b1, 4'd3, 3'b010, 1'b1);
        req_key = 12'h970;
        tick();
        check_all("legato", 1'b1, 4'd7, 3'b010, 1'b1);
        req_on = 3'b000;
        tick();
        wait_idle();

        // owner 2 playing, requester 0 rises
        req_on = 3'b100; req_key = 12'h205;
        tick();
        check_all("own2", 1'b1, 4'd2, 3'b100, 1'b1);
        req_on = 3'b101;
        tick();
        if (pre) begin
            exp_pc = 1;
            check_all("preempt", 1'b0, 4'd2, 3'b000, 1'b1);
            repeat (4) tick();
            chk("preempt_gap_grant", 32'(grant), 32'd0);
            tick();
            check_all("preempt_regrant", 1'b1, 4'd5, 3'b001, 1'b1);
        end else begin
            check_all("nopreempt", 1'b1, 4'd2, 3'b100, 1'b1);
            repeat (3) tick();
            check_all("nopreempt_hold", 1'b1, 4'd2, 3'b100, 1'b1);
            req_on = 3'b001;
            tick();
            check_all("nopreempt_rel", 1'b0, 4'd2, 3'b000, 1'b1);
            repeat (4) tick();
            chk("nopreempt_gap_grant", 32'(grant), 32'd0);
            tick();
            check_all("nopreempt_regrant", 1'b1, 4'd5, 3'b001, 1'b1);
        end
        req_on = 3'b000;
        tick();
        wait_idle();

        // release plus higher request in the same cycle counts as release
        req_on = 3'b100;
        tick();
        req_on = 3'b001;
        tick();
        check_all("rel_and_higher", 1'b0, 4'd2, 3'b000, 1'b1);
        req_on = 3'b000;
        wait_idle();

        // saturation stress
        for (int k = 0; k < 300; k++) begin
            req_on = 3'b100;
            tick();
            req_on = 3'b101;
            tick();
            req_on = 3'b000;
            tick();
            wait_idle();
        end
        exp_pc = pre ? 255 : 0;
        chk("pcnt_saturate", 32'(preempt_cnt), 32'(exp_pc));

        // asynchronous reset mid-PLAY
        req_on = 3'b001; req_key = 12'h00A;
        tick();
        chk("pre_rst_tone", 32'(tone_on), 32'd1);
        #2 rst = 1'b1;
        #1;
        exp_pc = 0;
        check_all("async_rst", 1'b0, 4'd0, 3'b000, 1'b0);
        req_on = 3'b010; req_key = 12'h0C0;
        #1 rst = 1'b0;
        tick();
        check_all("post_rst_grant", 1'b1, 4'hC, 3'b010, 1'b1);

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule
